mul_div_seq: RTL and testbench
==============================

// Module: mul_div_seq
// PURPOSE
//   Multi-cycle signed 32x32 multiply / 32/32 divide unit producing the 64-bit
//   result that the Z register captures. It is the writer side of the Z
//   interface: it drives z_data[63:0] and a one-cycle z_load strobe that is
//   wired to the Z register's ZInput. Operands come from the Y register (A)
//   and the bus (B). The control unit starts it and waits on done.
// PARAMETERS
//   WIDTH   32   operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//   clk       in   1        system clock, all state on rising edge
//   clr       in   1        synchronous reset, ACTIVE-LOW (clr==0 resets)
//   start     in   1        request; sampled only in IDLE
//   op        in   1        0 = MUL, 1 = DIV
//   a         in   WIDTH    multiplicand / dividend (two's complement)
//   b         in   WIDTH    multiplier / divisor (two's complement)
//   busy      out  1        high from the cycle after start is accepted until done
//   done      out  1        one-cycle pulse: result valid
//   z_load    out  1        identical to done; drives Z register ZInput
//   z_data    out  2*WIDTH  MUL: full product; DIV: {remainder, quotient}
//   div0      out  1        held with z_data: last DIV had b==0
// BEHAVIOUR
//   Reset (clr==0 at posedge): state=IDLE; busy=0, done=0, z_load=0,
//     z_data=0, div0=0. Reset has priority over everything, including mid-op:
//     the operation is abandoned, no done/z_load pulse is produced.
//   FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     IDLE: if start, latch a, b, op, and the operand signs; load the working
//       regs with magnitudes |a|, |b|; counter=0; go RUN.
//     RUN: exactly WIDTH cycles, one iteration per cycle; counter 0..WIDTH-1,
//       leave when counter==WIDTH-1.
//       MUL: unsigned shift-add on magnitudes, 2*WIDTH accumulator.
//       DIV: restoring divide on magnitudes, one quotient bit per cycle.
//     FIX: one cycle. Sign correction; load z_data.
//       MUL: negate product if sign(a)^sign(b).
//       DIV: quotient negated if sign(a)^sign(b); remainder takes sign of a.
//         Truncation toward zero.
//     DONE: done=1, z_load=1 for this single cycle; -> IDLE.
//   Latency: start sampled at edge N -> done high during cycle N+WIDTH+2
//     (34 cycles for WIDTH=32). Fixed, data-independent; no early termination.
//   z_data/div0 update only in FIX. They hold until the next FIX, so Z may
//     reload at any later time.
//   start while busy (RUN/FIX/DONE): ignored, no queuing. start in the DONE
//     cycle is also ignored; the controller re-asserts it after done.
//   op/a/b changing after acceptance: no effect (latched).
//   Divide by zero: the RUN/FIX timing is unchanged; quotient=all ones,
//     remainder=a (unmodified), div0=1. MUL clears div0.
//   Overflow: MUL cannot overflow 2*WIDTH. DIV of -2^(W-1) by -1 gives
//     quotient=-2^(W-1), remainder=0 (wraps, no flag).
//   Magnitude of -2^(W-1) is handled as an unsigned W-bit value 2^(W-1).
// STRUCTURE
//   Shared include (cpu_defs.vh): OP_MUL/OP_DIV encodings, FSM state encodings
//     (2-bit), WIDTH default.
//   Single module; the iteration datapath is not split out. The counter width
//     is $clog2(WIDTH).
// TESTING
//   1 MUL a=7, b=6 -> done exactly 34 cycles after start; z_data=64'h0000_0000_0000_002A.
//   2 MUL a=-3, b=5 -> z_data=64'hFFFF_FFFF_FFFF_FFF1.
//     MUL a=b=32'h8000_0000 -> z_data=64'h4000_0000_0000_0000.
//   3 DIV a=100, b=7 -> z_data={32'h2, 32'hE}, div0=0.
//     DIV a=-7, b=2 -> z_data={32'hFFFF_FFFF, 32'hFFFF_FFFD}.
//   4 DIV a=5, b=0 -> z_data={32'h5, 32'hFFFF_FFFF}, div0=1; a following MUL clears div0.
//   5 start pulsed again mid-RUN with other operands -> ignored; exactly one
//     done pulse, first result; z_load==done each cycle.
//   6 clr=0 in RUN cycle 10 -> next edge all outputs 0, state IDLE, no done pulse;
//     a new start after clr=1 completes normally.

Source files
------------

// File: rtl/mul_div_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Operation select, FSM states and the default operand width.
package mul_div_seq_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_div_seq.sv
// Multi-cycle signed multiply / divide feeding the Z register.
// Works on magnitudes for WIDTH cycles, then fixes signs in one cycle.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               z_load,
  output logic [2*WIDTH-1:0] z_data,
  output logic               div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_sub, div_nxt;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rmd_s;
  logic               unused_msb;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // MUL: hi accumulates, lo holds the multiplier and
  // collects low product bits as they shift out.
  assign mul_sum = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, d_q} : '0);

  // DIV: hi is the partial remainder, lo shifts the
  // dividend out and quotient bits in.
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, d_q};
  assign div_ge  = div_sh >= {1'b0, d_q};
  assign div_nxt = div_ge ? div_sub : div_sh;
  assign unused_msb = div_nxt[WIDTH];

  assign prod   = {hi_q, lo_q};
  assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rmd_s  = sa_q ? -hi_q : hi_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    a_d     = a_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    z_d     = z_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          hi_d    = '0;
          lo_d    = (op == OP_DIV) ? a_mag : b_mag;
          d_d     = (op == OP_DIV) ? b_mag : a_mag;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (op_q == OP_DIV) begin
          hi_d = div_nxt[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q == OP_MUL) begin
          z_d    = prod_s;
          div0_d = 1'b0;
        end else if (d_q == '0) begin
          z_d    = {a_q, {WIDTH{1'b1}}};
          div0_d = 1'b1;
        end else begin
          z_d    = {rmd_s, quo_s};
          div0_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      a_q     <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      a_q     <= a_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      z_q     <= z_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign z_load = done;
  assign z_data = z_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized bench for mul_div_seq against an arithmetic reference model.
// Literal results pin the model on directed operations.
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        z_load;
  logic [63:0] z_data;
  logic        div0;

  int errors = 0;
  int checks = 0;

  int   cyc = 0;
  int   due = 0;
  bit   pending = 1'b0;
  bit   armed = 1'b0;
  logic [63:0] pend_z = '0;
  logic [63:0] held_z = '0;
  logic        pend_d0 = 1'b0;
  logic        held_d0 = 1'b0;
  int   dut_dones = 0;
  int   exp_dones = 0;

  bit          pin_on = 1'b0;
  logic [63:0] pin_z = '0;
  logic        pin_d0 = 1'b0;
  bit          fin_req = 1'b0;
  bit          fin_ack = 1'b0;

  mul_div_seq dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .z_load (z_load),
    .z_data (z_data),
    .div0   (div0)
  );

  always #5 clk = ~clk;

  // {div0, z} straight from signed arithmetic
  function automatic logic [64:0] model(
    input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p = sx * sy;
      return {1'b0, p[63:0]};
    end
    if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h1;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 20));
      6: v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Model: one op in flight, result due 34 edges after acceptance
  always @(posedge clk) begin
    logic [64:0] r;
    cyc++;
    if (!clr) begin
      pending = 1'b0;
      held_z  = '0;
      held_d0 = 1'b0;
      armed   = 1'b1;
    end else begin
      if (!pending && start) begin
        r       = model(op, a, b);
        pend_z  = r[63:0];
        pend_d0 = r[64];
        pending = 1'b1;
        due     = cyc + 34;
      end else if (pending && cyc == due - 1) begin
        held_z  = pend_z;
        held_d0 = pend_d0;
      end
      if (pending && cyc == due) pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit ed;
    if (armed) begin
      ed = pending && (cyc + 1 == due);
      if (ed) exp_dones++;
      if (done) dut_dones++;
      chk("done",   64'(done),   64'(ed));
      chk("z_load", 64'(z_load), 64'(ed));
      chk("busy",   64'(busy),   64'(pending));
      chk("z_data", z_data,      held_z);
      chk("div0",   64'(div0),   64'(held_d0));
      if (ed && pin_on) begin
        chk("pin_model", held_z,      pin_z);
        chk("pin_z",     z_data,      pin_z);
        chk("pin_div0",  64'(div0),   64'(pin_d0));
      end
      if (fin_req && !fin_ack) begin
        chk("done_count", 64'(dut_dones), 64'(exp_dones));
        fin_ack = 1'b1;
      end
    end
  end

  task automatic start_op(input logic o,
                          input logic [31:0] x,
                          input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic dir(input logic o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [63:0] z,
                     input logic d0);
    pin_z = z;
    pin_d0 = d0;
    pin_on = 1'b1;
    start_op(o, x, y);
    repeat (34) @(posedge clk);
    #1;
    pin_on = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;

    dir(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b0);
    dir(1'b0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    dir(1'b0, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000, 1'b0);
    dir(1'b1, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b0);
    dir(1'b1, 32'hFFFF_FFF9, 32'd2,
        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    dir(1'b1, 32'd7, 32'hFFFF_FFFE,
        {32'h1, 32'hFFFF_FFFD}, 1'b0);
    dir(1'b1, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 1'b1);
    dir(1'b0, 32'd2, 32'd3, 64'h6, 1'b0);
    dir(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
        {32'h0, 32'h8000_0000}, 1'b0);

    // start re-pulsed mid-run with other operands
    pin_z = 64'd7006652;
    pin_d0 = 1'b0;
    pin_on = 1'b1;
    start_op(1'b0, 32'd1234, 32'd5678);
    repeat (5) @(posedge clk);
    #1;
    op = 1'b1;
    a = 32'd99;
    b = 32'd3;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    pin_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during RUN, then a normal op
    start_op(1'b1, 32'd12345, 32'd67);
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    dir(1'b1, 32'd1000, 32'd10, {32'h0, 32'h64}, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic        o;
      logic [31:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = pick();
      y = pick();
      if (o && $urandom_range(0, 7) == 0) y = 32'h0;
      start_op(o, x, y);
      for (int k = 0; k < 34; k++) begin
        start = ($urandom_range(0, 3) == 0);
        op = 1'($urandom);
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    fin_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!fin_ack) begin
      $display("FAIL fin_handshake no final check");
      $fatal(1, "final check not reached");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
